// File: rtl/serial_adder_if.sv
// Handshake/bus bundle for serial_adder.
//   master : drives start/a/b/cin, observes busy/done/sum/cout (requester side)
//   slave  : the adder itself
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, carry recirculated through
// a flop, one bit pair per clock LSB first.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_if.slave
//          start/a/b/cin sampled in IDLE; busy = not IDLE; done = one-cycle
//          pulse; sum/cout registered, held until the next completion.
// A start edge E0 is followed by WIDTH RUN edges; done is high in the cycle
// after E_WIDTH, and the unit is IDLE again after one more edge.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] acc_shift;

  full_adder u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
  assign acc_shift = WIDTH'({fa_s, acc_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        acc_d   = acc_shift;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = acc_shift;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered copies of the next state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] prev_sum;
  logic       prev_cout;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit add. poke>0 raises start with junk operands just before RUN
  // edge number poke; it must be ignored.
  task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec,
                        input int poke);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    tick();                                       // E0
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
    chk({tag, ".busy0"}, 32'(bus8.busy), 32'd1);
    chk({tag, ".done0"}, 32'(bus8.done), 32'd0);
    for (int i = 1; i < 8; i++) begin
      if (i == poke) begin
        bus8.start = 1'b1; bus8.a = 8'hF0; bus8.b = 8'hF0; bus8.cin = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      tick();                                     // E_i
      chk({tag, ".early_done"}, 32'(bus8.done), 32'd0);
      chk({tag, ".hold_sum"}, 32'({bus8.cout, bus8.sum}), 32'({prev_cout, prev_sum}));
    end
    bus8.start = 1'b0;
    tick();                                       // E_8
    chk({tag, ".done"}, 32'(bus8.done), 32'd1);
    chk({tag, ".busy_done"}, 32'(bus8.busy), 32'd1);
    chk({tag, ".sum"}, 32'(bus8.sum), 32'(es));
    chk({tag, ".cout"}, 32'(bus8.cout), 32'(ec));
    tick();                                       // back to IDLE
    chk({tag, ".done_pulse"}, 32'(bus8.done), 32'd0);
    chk({tag, ".idle"}, 32'(bus8.busy), 32'd0);
    chk({tag, ".keep_sum"}, 32'(bus8.sum), 32'(es));
    prev_sum = es; prev_cout = ec;
  endtask

  initial begin
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    prev_sum = 8'h00; prev_cout = 1'b0;

    // 1. reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst.busy", 32'(bus8.busy), 32'd0);
    chk("rst.done", 32'(bus8.done), 32'd0);
    chk("rst.sum",  32'(bus8.sum),  32'd0);
    chk("rst.cout", 32'(bus8.cout), 32'd0);
    chk("rst.w1",   32'({bus1.busy, bus1.done, bus1.cout, bus1.sum}), 32'd0);
    do_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);

    // 2. basic patterns
    do_add("0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);
    do_add("55aa", 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 0);

    // 3. carry boundaries
    do_add("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    do_add("ffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);

    // 4. start during RUN is ignored
    do_add("poke", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 3);
    tick();
    chk("poke.single_done", 32'(bus8.done), 32'd0);
    chk("poke.no_restart", 32'(bus8.busy), 32'd0);

    // 5. reset on the 4th RUN edge aborts
    bus8.start = 1'b1; bus8.a = 8'h77; bus8.b = 8'h11; bus8.cin = 1'b0;
    tick();                                       // E0
    bus8.start = 1'b0;
    tick(); tick(); tick();                       // E1..E3
    rst = 1'b1;
    tick();                                       // E4 under reset
    rst = 1'b0;
    chk("abort.busy", 32'(bus8.busy), 32'd0);
    chk("abort.done", 32'(bus8.done), 32'd0);
    chk("abort.sum",  32'({bus8.cout, bus8.sum}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort.no_done", 32'(bus8.done), 32'd0);
    end
    prev_sum = 8'h00; prev_cout = 1'b0;
    do_add("1234", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);

    // 6. back-to-back: second start lands in the first IDLE cycle
    do_add("b2b1", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0);
    do_add("b2b2", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 0);

    // WIDTH=1: 1+1+1 = 3 -> sum 1, cout 1, done after E1
    bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
    tick();                                       // E0
    bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0;
    chk("w1.busy",  32'(bus1.busy), 32'd1);
    chk("w1.early", 32'(bus1.done), 32'd0);
    tick();                                       // E1
    chk("w1.done",  32'(bus1.done), 32'd1);
    chk("w1.sum",   32'(bus1.sum),  32'd1);
    chk("w1.cout",  32'(bus1.cout), 32'd1);
    tick();
    chk("w1.pulse", 32'(bus1.done), 32'd0);
    chk("w1.idle",  32'(bus1.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
